// File: rtl/dma_param_fifo.sv
// dma_param_fifo: parametrised DMAC data FIFO with level flags, occupancy and sticky errors; define DMA_FIFO_FWFT_EN for first-word-fall-through reads
module dma_param_fifo #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              wr_acc, rd_acc;
  assign full         = count_q == DEPTH;
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= AF;
  assign almost_empty = count_q <= AE;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign wr_acc       = wr_en && !full;
  assign rd_acc       = rd_en && !empty;
  always_comb begin
    count_d     = wr_acc && !rd_acc ? count_q + ONE : rd_acc && !wr_acc ? count_q - ONE : count_q;
    overflow_d  = (wr_en && full) || (overflow_q && !clr_err);
    underflow_d = (rd_en && empty) || (underflow_q && !clr_err);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  always_ff @(posedge clk)
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
`ifdef DMA_FIFO_FWFT_EN
  assign rd_data  = mem_q[rd_ptr_q];
  assign rd_valid = !empty;
`else
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
      rd_valid_q <= rd_acc;
    end
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif
endmodule

// File: tb/tb_dma_param_fifo.sv
// tb_dma_param_fifo: directed self-checking bench for dma_param_fifo with default parameters
module tb_dma_param_fifo;
  logic        clk = 0, rst = 1, wr_en = 0, rd_en = 0, clr_err = 0;
  logic [15:0] wr_data = '0, rd_data;
  logic        rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]  count;
  int          pass_n = 0, total_n = 0;

  dma_param_fifo dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic w, input logic [15:0] d, input logic r);
    wr_en = w; wr_data = d; rd_en = r;
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0;
  endtask

  task automatic do_reset();
    rst = 1; clr_err = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    @(posedge clk); #1;
    total_n++; if (count !== 4'd0) $display("FAIL reset_count got %0d exp 0", count); else pass_n++;
    total_n++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else pass_n++;
    total_n++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else pass_n++;
    total_n++; if (almost_empty !== 1'b1) $display("FAIL reset_ae got %b exp 1", almost_empty); else pass_n++;
    total_n++; if (almost_full !== 1'b0) $display("FAIL reset_af got %b exp 0", almost_full); else pass_n++;
    total_n++; if ({rd_valid, overflow, underflow} !== 3'b000) $display("FAIL reset_vld_err got %b exp 000", {rd_valid, overflow, underflow}); else pass_n++;
    total_n++; if (rd_data !== 16'h0000) $display("FAIL reset_rd_data got %h exp 0000", rd_data); else pass_n++;
    rst = 0;
  endtask

  task automatic test_basic();
    logic [15:0] exp_d [3];
    exp_d[0] = 16'h0062; exp_d[1] = 16'h0072; exp_d[2] = 16'h0082;
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, exp_d[i], 0);
    total_n++; if (count !== 4'd3) $display("FAIL basic_count got %0d exp 3", count); else pass_n++;
    total_n++; if (empty !== 1'b0) $display("FAIL basic_empty got %b exp 0", empty); else pass_n++;
    total_n++; if (almost_empty !== 1'b0) $display("FAIL basic_ae got %b exp 0", almost_empty); else pass_n++;
    total_n++; if (rd_valid !== 1'b0) $display("FAIL basic_vld_idle got %b exp 0", rd_valid); else pass_n++;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 16'h0, 1);
      total_n++; if (rd_data !== exp_d[i]) $display("FAIL basic_rd%0d got %h exp %h", i, rd_data, exp_d[i]); else pass_n++;
      total_n++; if (rd_valid !== 1'b1) $display("FAIL basic_vld%0d got %b exp 1", i, rd_valid); else pass_n++;
    end
    total_n++; if (empty !== 1'b1 || count !== 4'd0) $display("FAIL basic_drained got empty=%b count=%0d exp 1/0", empty, count); else pass_n++;
    cyc(0, 16'h0, 0);
    total_n++; if (rd_valid !== 1'b0) $display("FAIL basic_vld_drop got %b exp 0", rd_valid); else pass_n++;
    total_n++; if (rd_data !== 16'h0082) $display("FAIL basic_hold got %h exp 0082", rd_data); else pass_n++;
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1, 16'h00B0 + 16'(i), 0);
      total_n++; if (almost_full !== (i + 1 >= 6)) $display("FAIL ovf_af%0d got %b exp %b", i, almost_full, i + 1 >= 6); else pass_n++;
      total_n++; if (full !== (i + 1 == 8)) $display("FAIL ovf_full%0d got %b exp %b", i, full, i + 1 == 8); else pass_n++;
    end
    total_n++; if (overflow !== 1'b0) $display("FAIL ovf_pre got %b exp 0", overflow); else pass_n++;
    cyc(1, 16'h00EE, 0);
    total_n++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", overflow); else pass_n++;
    total_n++; if (count !== 4'd8) $display("FAIL ovf_count got %0d exp 8", count); else pass_n++;
    clr_err = 1; cyc(0, 16'h0, 0); clr_err = 0;
    total_n++; if (overflow !== 1'b0) $display("FAIL ovf_clr got %b exp 0", overflow); else pass_n++;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 16'h0, 1);
      total_n++; if (rd_data !== 16'h00B0 + 16'(i)) $display("FAIL ovf_rd%0d got %h exp %h", i, rd_data, 16'h00B0 + 16'(i)); else pass_n++;
    end
    total_n++; if (empty !== 1'b1) $display("FAIL ovf_empty got %b exp 1", empty); else pass_n++;
  endtask

  task automatic test_underflow();
    do_reset();
    cyc(0, 16'h0, 1);
    total_n++; if (underflow !== 1'b1) $display("FAIL udf_set got %b exp 1", underflow); else pass_n++;
    total_n++; if (rd_valid !== 1'b0) $display("FAIL udf_vld got %b exp 0", rd_valid); else pass_n++;
    total_n++; if (count !== 4'd0) $display("FAIL udf_count got %0d exp 0", count); else pass_n++;
    clr_err = 1; cyc(0, 16'h0, 0); clr_err = 0;
    total_n++; if (underflow !== 1'b0) $display("FAIL udf_clr got %b exp 0", underflow); else pass_n++;
    clr_err = 1; cyc(1, 16'h0033, 1); clr_err = 0;
    total_n++; if (count !== 4'd1) $display("FAIL udf_wr_count got %0d exp 1", count); else pass_n++;
    total_n++; if (underflow !== 1'b1) $display("FAIL udf_wins_clr got %b exp 1", underflow); else pass_n++;
    total_n++; if (rd_valid !== 1'b0) $display("FAIL udf_wr_vld got %b exp 0", rd_valid); else pass_n++;
    cyc(0, 16'h0, 1);
    total_n++; if (rd_data !== 16'h0033 || rd_valid !== 1'b1) $display("FAIL udf_rd got %h/%b exp 0033/1", rd_data, rd_valid); else pass_n++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] q[$];
    logic [15:0] exp_d;
    logic        can_rd, can_wr;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1, 16'(i), 0);
      q.push_back(16'(i));
    end
    for (int k = 0; k < 20; k++) begin
      can_rd = q.size() != 0;
      can_wr = q.size() != 8;
      exp_d = can_rd ? q.pop_front() : 16'h0;
      if (can_wr) q.push_back(16'(8 + k));
      cyc(1, 16'(8 + k), 1);
      total_n++; if (rd_data !== exp_d || rd_valid !== 1'b1) $display("FAIL b2b_rd%0d got %h/%b exp %h/1", k, rd_data, rd_valid, exp_d); else pass_n++;
      total_n++; if (count !== 4'(q.size())) $display("FAIL b2b_count%0d got %0d exp %0d", k, count, q.size()); else pass_n++;
    end
    total_n++; if (overflow !== 1'b1) $display("FAIL b2b_ovf got %b exp 1", overflow); else pass_n++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    cyc(1, 16'h0011, 0);
    cyc(1, 16'h0022, 0);
    cyc(1, 16'h0033, 1);
    total_n++; if (rd_valid !== 1'b1 || count !== 4'd2) $display("FAIL mrst_pre got %b/%0d exp 1/2", rd_valid, count); else pass_n++;
    rst = 1; #1;
    total_n++; if (count !== 4'd0) $display("FAIL mrst_count got %0d exp 0", count); else pass_n++;
    total_n++; if (empty !== 1'b1) $display("FAIL mrst_empty got %b exp 1", empty); else pass_n++;
    total_n++; if (rd_valid !== 1'b0) $display("FAIL mrst_vld got %b exp 0", rd_valid); else pass_n++;
    #1 rst = 0;
    cyc(1, 16'h005A, 0);
    total_n++; if (count !== 4'd1) $display("FAIL mrst_wr got %0d exp 1", count); else pass_n++;
    cyc(0, 16'h0, 1);
    total_n++; if (rd_data !== 16'h005A) $display("FAIL mrst_rd got %h exp 005a", rd_data); else pass_n++;
    total_n++; if (empty !== 1'b1) $display("FAIL mrst_empty2 got %b exp 1", empty); else pass_n++;
  endtask

`ifdef DMA_FIFO_FWFT_EN
  task automatic test_fwft();
    do_reset();
    cyc(1, 16'h00A5, 0);
    total_n++; if (rd_data !== 16'h00A5 || rd_valid !== 1'b1) $display("FAIL fwft_head got %h/%b exp 00a5/1", rd_data, rd_valid); else pass_n++;
    cyc(0, 16'h0, 1);
    total_n++; if (empty !== 1'b1 || rd_valid !== 1'b0) $display("FAIL fwft_pop got %b/%b exp 1/0", empty, rd_valid); else pass_n++;
  endtask
`endif

  initial begin
    test_reset();
`ifdef DMA_FIFO_FWFT_EN
    test_fwft();
`else
    test_basic();
    test_full_overflow();
    test_underflow();
    test_back_to_back();
    test_mid_reset();
`endif
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
